// File: rtl/dmem_responder.sv
// Data-memory target for the core's data bus: word-organised SRAM model with
// configurable wait states, byte-lane merging on stores and a one-cycle ACKD_n.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_8000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  input  logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  output logic        ACKD_n,
  output logic        err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        write_q, fault_q;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the access happens on the sampling edge itself, so
  // the request is taken straight from the bus while still in IDLE.
  logic        from_bus;
  logic [31:0] cur_addr, cur_wdata, off, wshift, rshift, rext;
  logic [1:0]  cur_size, lane;
  logic        cur_write, fault, enter_ack;
  logic [AW-1:0] idx;
  logic [3:0]  be;

  assign from_bus  = (state_q == ST_IDLE);
  assign cur_addr  = from_bus ? DAD   : addr_q;
  assign cur_size  = from_bus ? SIZE  : size_q;
  assign cur_write = from_bus ? WRITE : write_q;
  assign cur_wdata = from_bus ? DDT   : wdata_q;

  assign off  = cur_addr - BASE_ADDR;
  assign lane = off[1:0];
  assign idx  = off[AW+1:2];

  assign fault = (cur_addr < BASE_ADDR) || ({1'b0, off} >= SPAN) ||
                 (cur_size == 2'b11) ||
                 (cur_size == 2'b01 && lane[0]) ||
                 (cur_size == 2'b00 && lane != 2'b00);

  assign wshift = cur_wdata << {lane, 3'b000};
  assign rshift = mem[idx] >> {lane, 3'b000};

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    be   = 4'b0000;
    rext = 32'h0;
    case (cur_size)
      2'b00: begin be = 4'b1111;          rext = rshift;                 end
      2'b01: begin be = 4'b0011 << lane;  rext = {16'h0, rshift[15:0]};  end
      2'b10: begin be = 4'b0001 << lane;  rext = {24'h0, rshift[7:0]};   end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (MREQ) begin
        if (WAIT_CYCLES == 0) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 4'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = ST_ACK;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_ack = (state_d == ST_ACK);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the blocks are evaluated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      write_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && MREQ) begin
        addr_q  <= DAD;
        size_q  <= SIZE;
        write_q <= WRITE;
        wdata_q <= DDT;
      end
      if (enter_ack) fault_q <= fault;
    end
  end

  // NOTE: the array is deliberately left out of reset so its contents survive
  // it; the rst term only keeps an edge inside reset from committing a store.
  always_ff @(posedge clk) begin
    if (rst && enter_ack) begin
      if (cur_write && !fault) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
        end
      end
      rdata_q <= fault ? 32'h0 : rext;
    end
  end

  assign ACKD_n = (state_q != ST_ACK);
  assign err    = (state_q == ST_ACK) && fault_q;
  assign DDT    = (state_q == ST_ACK && !write_q) ? rdata_q : 32'bz;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: five instances with different wait-state counts, a
// byte-addressed reference memory and a per-cycle compare of ACKD_n/err/DDT.
module tb_dmem_responder;

  localparam logic [31:0] BASE     = 32'h0000_8000;
  localparam int          DEPTH    = 1024;
  localparam int          WC [5]   = '{1, 0, 3, 15, 4};
  // Each DDT net carries a pull-up, so a released bus reads as all ones.
  localparam logic [31:0] IDLE_BUS = 32'hFFFF_FFFF;

  typedef struct {
    int          dut;
    int          due;
    bit          err;
    bit          load;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  mreq = 5'b0;
  logic        wr = 1'b0;
  logic [1:0]  sz = 2'b00;
  logic [31:0] dad = 32'h0;
  logic [31:0] ddt_drv = 32'h0;
  logic        ddt_oe = 1'b0;
  int          sel = 0;
  wire  [4:0]  ackd_n, errv;
  wire  [31:0] ddt0, ddt1, ddt2, ddt3, ddt4;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;
  exp_t sb [$];
  logic [7:0] mb [longint];

  assign ddt0 = (ddt_oe && sel == 0) ? ddt_drv : 32'bz;
  assign ddt1 = (ddt_oe && sel == 1) ? ddt_drv : 32'bz;
  assign ddt2 = (ddt_oe && sel == 2) ? ddt_drv : 32'bz;
  assign ddt3 = (ddt_oe && sel == 3) ? ddt_drv : 32'bz;
  assign ddt4 = (ddt_oe && sel == 4) ? ddt_drv : 32'bz;
  pullup (ddt0);
  pullup (ddt1);
  pullup (ddt2);
  pullup (ddt3);
  pullup (ddt4);

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WC[0])) u_dut0 (
    .clk(clk), .rst(rst), .MREQ(mreq[0]), .WRITE(wr), .SIZE(sz), .DAD(dad),
    .DDT(ddt0), .ACKD_n(ackd_n[0]), .err(errv[0]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WC[1])) u_dut1 (
    .clk(clk), .rst(rst), .MREQ(mreq[1]), .WRITE(wr), .SIZE(sz), .DAD(dad),
    .DDT(ddt1), .ACKD_n(ackd_n[1]), .err(errv[1]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WC[2])) u_dut2 (
    .clk(clk), .rst(rst), .MREQ(mreq[2]), .WRITE(wr), .SIZE(sz), .DAD(dad),
    .DDT(ddt2), .ACKD_n(ackd_n[2]), .err(errv[2]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WC[3])) u_dut3 (
    .clk(clk), .rst(rst), .MREQ(mreq[3]), .WRITE(wr), .SIZE(sz), .DAD(dad),
    .DDT(ddt3), .ACKD_n(ackd_n[3]), .err(errv[3]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WC[4])) u_dut4 (
    .clk(clk), .rst(rst), .MREQ(mreq[4]), .WRITE(wr), .SIZE(sz), .DAD(dad),
    .DDT(ddt4), .ACKD_n(ackd_n[4]), .err(errv[4]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ddt_of(int d);
    case (d)
      0:       return ddt0;
      1:       return ddt1;
      2:       return ddt2;
      3:       return ddt3;
      default: return ddt4;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference memory: a flat byte store, little-endian, one region per instance.
  function automatic void model_access(int d, bit w, logic [1:0] s, logic [31:0] a,
                                       logic [31:0] wd, output bit e, output logic [31:0] rd);
    longint off = longint'(a) - longint'(BASE);
    int n = (s == 2'b00) ? 4 : (s == 2'b01) ? 2 : (s == 2'b10) ? 1 : 0;
    rd = 32'h0;
    e  = (off < 0) || (off >= 4 * DEPTH) || (n == 0) || (off % n != 0);
    if (!e) begin
      for (int i = 0; i < n; i++) begin
        longint key = longint'(d) * 64'd1048576 + off + longint'(i);
        if (w) mb[key] = wd[8*i +: 8];
        else   rd[8*i +: 8] = mb.exists(key) ? mb[key] : 8'hxx;
      end
    end
  endfunction

  always @(negedge clk) begin : compare
    bit          hit, e_err, e_load;
    logic [31:0] e_data, exp_bus;
    if (chk_en) begin
      for (int d = 0; d < 5; d++) begin
        hit = 1'b0; e_err = 1'b0; e_load = 1'b0; e_data = 32'h0;
        foreach (sb[i]) begin
          if (sb[i].dut == d && sb[i].due == cyc) begin
            hit = 1'b1; e_err = sb[i].err; e_load = sb[i].load; e_data = sb[i].data;
          end
        end
        exp_bus = (ddt_oe && sel == d) ? ddt_drv : (hit && e_load) ? e_data : IDLE_BUS;
        check($sformatf("ackd_n_dut%0d", d), 32'(ackd_n[d]), 32'(!hit));
        check($sformatf("err_dut%0d", d), 32'(errv[d]), 32'(e_err));
        check($sformatf("ddt_dut%0d", d), ddt_of(d), exp_bus);
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) sb.delete(i);
      end
    end
  end

  task automatic req(int d, bit w, logic [1:0] s, logic [31:0] a, logic [31:0] wd,
                     output logic [31:0] rd, output bit e, output int lat);
    bit          me, seen;
    logic [31:0] mrd;
    int          k;
    sel = d; wr = w; sz = s; dad = a; ddt_drv = wd; ddt_oe = w; mreq[d] = 1'b1;
    @(posedge clk); #1;
    k = cyc; mreq[d] = 1'b0; ddt_oe = 1'b0;
    model_access(d, w, s, a, wd, me, mrd);
    sb.push_back('{dut: d, due: k + WC[d], err: me, load: !w, data: mrd});
    lat = 0; seen = 1'b0; rd = 32'h0; e = 1'b0;
    for (int t = 1; t <= 40 && !seen; t++) begin
      if (ackd_n[d] == 1'b0) begin
        seen = 1'b1; lat = t; rd = ddt_of(d); e = errv[d];
      end else begin
        @(posedge clk); #1;
      end
    end
    check($sformatf("ack_seen_dut%0d", d), 32'(seen), 32'd1);
    if (seen) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic burst(int d, int n, logic [31:0] a, logic [31:0] wd);
    int          k, last;
    int          acks [$];
    bit          me;
    logic [31:0] mrd;
    sel = d; wr = 1'b1; sz = 2'b00; dad = a; ddt_drv = wd; ddt_oe = 1'b1; mreq[d] = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    last = k + (n - 1) * (WC[d] + 2);
    for (int j = 0; j < n; j++) begin
      model_access(d, 1'b1, 2'b00, a, wd, me, mrd);
      sb.push_back('{dut: d, due: k + j * (WC[d] + 2) + WC[d], err: me, load: 1'b0, data: mrd});
    end
    while (cyc <= last + WC[d] + 1) begin
      if (ackd_n[d] == 1'b0) acks.push_back(cyc);
      if (cyc == last) begin
        mreq[d] = 1'b0; ddt_oe = 1'b0;
      end
      @(posedge clk); #1;
    end
    check($sformatf("burst_count_dut%0d", d), 32'(acks.size()), 32'(n));
    foreach (acks[j]) begin
      check($sformatf("burst_ack%0d_dut%0d", j, d), 32'(acks[j] - k),
            32'(j * (WC[d] + 2) + WC[d]));
    end
  endtask

  initial begin
    logic [31:0] rd;
    bit          e;
    int          lat, nack;

    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 5; d++) begin
      check($sformatf("reset_ackd_n_dut%0d", d), 32'(ackd_n[d]), 32'd1);
      check($sformatf("reset_err_dut%0d", d), 32'(errv[d]), 32'd0);
      check($sformatf("reset_ddt_dut%0d", d), ddt_of(d), IDLE_BUS);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Read-after-write and first-transaction latency, WAIT_CYCLES=1.
    req(0, 1'b1, 2'b00, 32'h8000, 32'hDEAD_BEEF, rd, e, lat);
    check("store_latency_w1", 32'(lat), 32'd2);
    check("store_err", 32'(e), 32'd0);
    req(0, 1'b0, 2'b00, 32'h8000, 32'h0, rd, e, lat);
    check("raw_word", rd, 32'hDEAD_BEEF);
    check("raw_latency", 32'(lat), 32'd2);
    check("ddt_released_after_ack", ddt0, IDLE_BUS);

    // Byte and halfword lane merging and extraction.
    req(0, 1'b1, 2'b10, 32'h8002, 32'h0000_0011, rd, e, lat);
    req(0, 1'b0, 2'b00, 32'h8000, 32'h0, rd, e, lat);
    check("byte_store_merge", rd, 32'hDE11_BEEF);
    req(0, 1'b1, 2'b01, 32'h8000, 32'h0000_2233, rd, e, lat);
    req(0, 1'b0, 2'b00, 32'h8000, 32'h0, rd, e, lat);
    check("half_store_merge", rd, 32'hDE11_2233);
    req(0, 1'b0, 2'b10, 32'h8003, 32'h0, rd, e, lat);
    check("byte_load_lane3", rd, 32'h0000_00DE);
    req(0, 1'b0, 2'b01, 32'h8002, 32'h0, rd, e, lat);
    check("half_load_lane2", rd, 32'h0000_DE11);

    // Faulted requests still acknowledge, with err set.
    req(0, 1'b0, 2'b00, 32'h8001, 32'h0, rd, e, lat);
    check("misaligned_word_err", 32'(e), 32'd1);
    check("misaligned_word_data", rd, 32'h0);
    req(0, 1'b1, 2'b01, 32'h8003, 32'h0000_FFFF, rd, e, lat);
    check("misaligned_half_err", 32'(e), 32'd1);
    req(0, 1'b0, 2'b00, 32'h8000, 32'h0, rd, e, lat);
    check("misaligned_half_no_write", rd, 32'hDE11_2233);
    req(0, 1'b0, 2'b00, 32'h7FFC, 32'h0, rd, e, lat);
    check("below_base_err", 32'(e), 32'd1);
    check("below_base_data", rd, 32'h0);
    req(0, 1'b1, 2'b11, 32'h8000, 32'hFFFF_FFFF, rd, e, lat);
    check("size11_err", 32'(e), 32'd1);
    req(0, 1'b0, 2'b00, 32'h8000, 32'h0, rd, e, lat);
    check("size11_no_write", rd, 32'hDE11_2233);
    req(0, 1'b0, 2'b00, 32'h9000, 32'h0, rd, e, lat);
    check("above_top_err", 32'(e), 32'd1);
    req(0, 1'b1, 2'b00, 32'h8FFC, 32'hA5A5_0F0F, rd, e, lat);
    check("top_word_store_err", 32'(e), 32'd0);
    req(0, 1'b0, 2'b00, 32'h8FFC, 32'h0, rd, e, lat);
    check("top_word_load", rd, 32'hA5A5_0F0F);

    // Wait-state sweep.
    req(1, 1'b1, 2'b00, 32'h8000, 32'hDEAD_BEEF, rd, e, lat);
    check("latency_w0", 32'(lat), 32'd1);
    req(1, 1'b0, 2'b00, 32'h8000, 32'h0, rd, e, lat);
    check("load_w0", rd, 32'hDEAD_BEEF);
    req(2, 1'b1, 2'b00, 32'h8000, 32'hDEAD_BEEF, rd, e, lat);
    check("latency_w3", 32'(lat), 32'd4);
    req(3, 1'b1, 2'b00, 32'h8000, 32'hDEAD_BEEF, rd, e, lat);
    check("latency_w15", 32'(lat), 32'd16);
    burst(1, 3, 32'h8004, 32'h1357_9BDF);
    burst(2, 3, 32'h8004, 32'h2468_ACE0);

    // Reset while a store sits in WAIT: no acknowledge and no write.
    req(4, 1'b1, 2'b00, 32'h8010, 32'h1234_5678, rd, e, lat);
    check("latency_w4", 32'(lat), 32'd5);
    sel = 4; wr = 1'b1; sz = 2'b00; dad = 32'h8010; ddt_drv = 32'hCAFE_F00D;
    ddt_oe = 1'b1; mreq[4] = 1'b1;
    @(posedge clk); #1;
    mreq[4] = 1'b0; ddt_oe = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    nack = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ackd_n[4] == 1'b0) nack++;
    end
    check("abort_no_ack", 32'(nack), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    req(4, 0, 2'b00, 32'h8010, 32'h0, rd, e, lat);
    check("abort_old_contents", rd, 32'h1234_5678);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the pipelined core's data bus.
- Samples MREQ, WRITE, SIZE, DAD and DDT from the core, models a word-organised SRAM with a configurable number of wait states, and answers each request with a one-cycle active-low ACKD_n.
- On reads it drives DDT. On writes it performs byte-lane merging.
- Sits at the top level beside the core, on the bus side opposite the core's memory stage.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array. Power of two.
- BASE_ADDR, 32'h0000_8000: byte address of word 0. Word aligned.
- WAIT_CYCLES, 1: cycles spent in WAIT before the acknowledge. Range 0..15.

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- MREQ  input  1  request valid, active high.
- WRITE  input  1  1 = store, 0 = load. Valid with MREQ.
- SIZE  input  2  access size: 2'b00 word, 2'b01 halfword, 2'b10 byte. 2'b11 is illegal.
- DAD  input  32  byte address.
- DDT  inout  32  store data in, right-aligned. Load data out, right-aligned and zero-extended.
- ACKD_n  output  1  transfer acknowledge, active low, exactly one cycle per request.
- err  output  1  high in the ACK cycle of a faulted request.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the wait counter clears.
  - Outputs: ACKD_n=1, err=0, DDT=Z.
  - The array contents are not cleared.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If MREQ=1 at the clock edge, latch DAD, SIZE, WRITE and DDT (store data).
  - Go to WAIT if WAIT_CYCLES>0, otherwise go to ACK.
- WAIT:
  - The counter counts from 1 to WAIT_CYCLES, then the FSM goes to ACK.
  - Bus inputs are ignored while in WAIT.
- ACK:
  - Lasts one cycle. ACKD_n=0 and err is set to the latched fault flag.
  - Always returns to IDLE.
- Latency: ACKD_n goes low exactly WAIT_CYCLES+1 cycles after the edge at which MREQ was sampled.
- Back-to-back requests: the next request can be sampled on the first edge in IDLE after ACK, so the minimum spacing between requests is WAIT_CYCLES+2 cycles. The core must drop MREQ, or present a new request, in the cycle after ACK. MREQ held high there is treated as a new request.
- Address decode:
  - offset = latched DAD - BASE_ADDR.
  - Word index = offset[log2(DEPTH_WORDS)+1:2].
  - Lane = offset[1:0].
- Fault conditions (any one sets the fault flag):
  - Out of range: DAD < BASE_ADDR, or offset >= 4*DEPTH_WORDS.
  - SIZE=2'b11.
  - Halfword with lane[0]=1.
  - Word with lane != 0.
- Faulted request:
  - No array write occurs.
  - Read data is 32'h0.
  - ACKD_n still pulses and err=1.
- Stores:
  - Committed on the edge that enters ACK.
  - Byte store: latched DDT[7:0] goes to byte lane `lane`.
  - Halfword store: DDT[15:0] goes to lanes {lane+1, lane}.
  - Word store: full word.
  - Unselected bytes are unchanged. Little-endian.
- Loads:
  - The array word is read when entering ACK. A read of a word stored by the immediately preceding request returns the new value.
  - During ACK only, DDT is driven with the extracted value:
    - byte: {24'b0, byte[lane]}
    - halfword: {16'b0, half}
    - word: whole word
  - Sign extension is the core's responsibility.
- DDT drive rule: DDT is Z in every state except ACK with latched WRITE=0. It is never driven during a store, so there is no contention with the core.
- Reset mid-operation: a request in WAIT is abandoned and no write is performed. A store is lost only if rst asserts before the edge entering ACK.
- Wait-counter width: 4 bits. WAIT_CYCLES=0 skips WAIT entirely.

Test Plan:
- Reset check: rst=0 then released. Required: ACKD_n=1, err=0, DDT=Z. A store of 32'hDEADBEEF to 32'h8000 with WAIT_CYCLES=1 gives ACKD_n low exactly 2 cycles after MREQ is sampled.
- Read-after-write: store 32'hDEADBEEF to 32'h8000, then load a word from 32'h8000. Required: DDT=32'hDEADBEEF during the ACK cycle and Z before and after it.
- Byte and halfword lanes: starting from 32'hDEADBEEF at 32'h8000:
  - store byte 8'h11 to 32'h8002 → word becomes 32'hDE11BEEF.
  - store half 16'h2233 to 32'h8000 → word becomes 32'hDE112233.
  - load byte from 32'h8003 → 32'h000000DE.
  - load half from 32'h8002 → 32'h0000DE11.
- Faults, each with ACKD_n pulsing and err=1:
  - word load at 32'h8001 → returns 0.
  - halfword store at 32'h8003 → memory unchanged.
  - load at 32'h7FFC → returns 0.
  - SIZE=2'b11 → memory unchanged.
- Wait-state sweep: WAIT_CYCLES=0, 3 and 15. Required: ACKD_n low at 1, 4 and 16 cycles after sampling. MREQ held continuously gives requests spaced WAIT_CYCLES+2 apart.
- Reset mid-operation: WAIT_CYCLES=4, store 32'hCAFEF00D to 32'h8010, assert rst in WAIT cycle 2. Required: no ACKD_n, and a following load from 32'h8010 returns the old contents.
